sram_banked_mp: RTL
===================

# sram_banked_mp

Multi-port, word-interleaved banked SRAM with per-port request/grant arbitration and a fixed, parametrised read latency. It supersedes the single-port byte-enable SRAM wrapper wherever several masters (e.g. I$/D$ refill and a debug or DMA port) share one on-chip memory. Conflicting requests to the same bank are resolved by per-bank round-robin arbitration. Read data returns on the requesting port with an `rvalid` strobe.

## Interface
- `DATA_WIDTH`, 64: word width in bits; any value ≥ 8.
- `NUM_WORDS`, 1024: total words; power of two and a multiple of `NUM_BANKS`.
- `NUM_BANKS`, 2: power of two, ≥ 1; bank = low address bits.
- `NUM_PORTS`, 2: master ports, ≥ 1.
- `OUT_REGS`, 0: 0 or 1; adds an output register stage; read latency = 1 + `OUT_REGS`.
- Derived: `AW = $clog2(NUM_WORDS)`, `BW = (DATA_WIDTH+7)/8`, `BKW = $clog2(NUM_BANKS)`, `LAT = 1 + OUT_REGS`.
- `clk_i`  in  1  clock; all logic rising-edge.
- `rst_ni`  in  1  reset: one clock, synchronous, active-low.
- `req_i`  in  [NUM_PORTS]  access request, held until granted.
- `we_i`  in  [NUM_PORTS]  1 = write, 0 = read.
- `addr_i`  in  [NUM_PORTS][AW]  word address.
- `wdata_i`  in  [NUM_PORTS][DATA_WIDTH]  write data.
- `be_i`  in  [NUM_PORTS][BW]  byte enables; bit k covers bits [8k+7:8k]; top byte may be partial.
- `gnt_o`  out  [NUM_PORTS]  combinational grant; the access happens when `req_i && gnt_o`.
- `rvalid_o`  out  [NUM_PORTS]  read data valid, exactly `LAT` cycles after a granted read.
- `rdata_o`  out  [NUM_PORTS][DATA_WIDTH]  read data; forced to 0 while `rvalid_o` is low.

## Operation
- Address split: bank = `addr[BKW-1:0]`, row = `addr[AW-1:BKW]`. When `NUM_BANKS` = 1, the bank field is absent and all requests target bank 0.
- Each bank has one round-robin pointer `rr_q[b]` in [0, NUM_PORTS-1]. Among the ports requesting bank b, the first one found scanning upward from `rr_q[b]` (wrapping) is granted.
- After a grant to port p on bank b, `rr_q[b]` becomes `(p+1) mod NUM_PORTS`. Pointers of banks without a grant are unchanged.
- Each port receives at most one grant per cycle. Different banks are accessed fully in parallel.
- `gnt_o` depends only on current `req_i`/`addr_i` and `rr_q`. It must not depend on `we_i`, `wdata_i` or `be_i`.
- Granted write: only the enabled bytes of the row are updated at the clock edge. `be_i` = 0 is a legal no-op write; it is still granted and still advances the pointer. No `rvalid` is produced for writes.
- Granted read: returns the row contents as of before the edge. A write to the same row by a different port is impossible in the same cycle because only one access per bank is granted.
- Response routing: each port has a `LAT`-deep shift pipeline of {valid, bank index}. Stage 0 loads `req && gnt && !we`. `rdata_o[p]` is taken from the bank named in the final stage.
- Memory contents are not reset. A read of an unwritten row returns X in simulation.

## Timing
- Reset values: `rr_q` = 0 for all banks, all response pipelines invalid, `rvalid_o` = 0, `rdata_o` = 0. While `rst_ni` = 0, `gnt_o` = 0.
- A read granted in cycle t has `rvalid_o` = 1 in cycle t+LAT for exactly one cycle.
- Back-to-back granted reads on one port give `rvalid_o` high in consecutive cycles. Throughput is one access per port per cycle when there is no conflict.
- Write data is visible to any read granted in cycle t+1 or later.
- Reset asserted mid-operation: all in-flight reads are dropped and no `rvalid_o` follows. Writes granted in the cycle reset is sampled low are suppressed.
- A requester that is not granted must hold its request. No fairness guarantee beyond round-robin: worst-case wait is `NUM_PORTS-1` grants on that bank.

## Structure
- The package `sram_banked_pkg` holds the `LAT` and address-split helper functions and a response-pipeline entry struct typedef {valid, bank}.
- The storage sub-module is `sram_bank_be`: single-port, byte-enable, synchronous read, optional output register via `OUT_REGS`. It is instantiated `NUM_BANKS` times, each with `NUM_WORDS/NUM_BANKS` rows.
- Arbitration and response pipelines live in the top module; no further sub-modules.

## Test plan
- `NUM_BANKS`=2, `OUT_REGS`=0: port 0 writes 0x1122334455667788 to addr 4, then reads addr 4. Required: read granted immediately, `rvalid_o[0]` one cycle after the grant, data 0x1122334455667788.
- Byte enables: write 0xFFFF…FF to addr 6, then write 0 with `be`=0x0F, then read. Required: 0xFFFFFFFF00000000.
- Conflict: both ports request bank 0 every cycle for 4 cycles from reset. Required grants P0, P1, P0, P1. The same test on addresses 2 and 3 (different banks) must grant both ports every cycle.
- `OUT_REGS`=1: read granted in cycle t gives `rvalid_o` only in cycle t+2, with `rdata_o` = 0 in cycle t+1.
- Reset mid-flight: assert `rst_ni`=0 the cycle after a read grant. Required: no `rvalid_o`, round-robin pointers back to 0, and a subsequent conflict grants P0 first.
- `DATA_WIDTH`=36: `BW`=5; a write with `be`=0x10 updates only bits [35:32].

Source files
------------

// File: rtl/sram_banked_pkg.sv
// Shared helpers for the banked multi-port SRAM: latency, address split and
// the response-pipeline entry that tracks which bank owns a returning read.
package sram_banked_pkg;

  localparam int unsigned MAX_BANK_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [MAX_BANK_W-1:0] bank;
  } rsp_ent_t;

  function automatic int unsigned lat_of(int unsigned out_regs);
    return 1 + out_regs;
  endfunction

  // Banks are a power of two, so modulo/divide reduce to low/high address bits.
  function automatic int unsigned bank_of(int unsigned addr, int unsigned nbanks);
    return addr % nbanks;
  endfunction

  function automatic int unsigned row_of(int unsigned addr, int unsigned nbanks);
    return addr / nbanks;
  endfunction

endpackage

// File: rtl/sram_bank_be.sv
// Single-port byte-enable SRAM bank with synchronous read and an optional
// output register; contents and read data are intentionally not reset.
module sram_bank_be #(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned NUM_ROWS   = 512,
  parameter  int unsigned OUT_REGS   = 0,
  localparam int unsigned BW         = (DATA_WIDTH + 7) / 8,
  localparam int unsigned RW         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [RW-1:0]         row_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BW-1:0]         be_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_ROWS];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] wmask;

  // Byte enables expand to a bit mask; the top byte may cover fewer than 8 bits.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) wmask[i] = be_i[i/8];
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[row_i] <= (mem_q[row_i] & ~wmask) | (wdata_i & wmask);
      else      rd_q         <= mem_q[row_i];
    end
  end

  if (OUT_REGS != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] rd2_q;
    always_ff @(posedge clk_i) rd2_q <= rd_q;
    assign rdata_o = rd2_q;
  end else begin : g_noreg
    assign rdata_o = rd_q;
  end

endmodule

// File: rtl/sram_banked_mp.sv
// Multi-port word-interleaved banked SRAM: per-bank round-robin arbitration,
// parallel bank access and fixed-latency read responses per port.
module sram_banked_mp
  import sram_banked_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned NUM_WORDS  = 1024,
  parameter  int unsigned NUM_BANKS  = 2,
  parameter  int unsigned NUM_PORTS  = 2,
  parameter  int unsigned OUT_REGS   = 0,
  localparam int unsigned AW         = $clog2(NUM_WORDS),
  localparam int unsigned BW         = (DATA_WIDTH + 7) / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0]                 we_i,
  input  logic [NUM_PORTS-1:0][AW-1:0]         addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS-1:0][BW-1:0]         be_i,
  output logic [NUM_PORTS-1:0]                 gnt_o,
  output logic [NUM_PORTS-1:0]                 rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned BKW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned ROWS = NUM_WORDS / NUM_BANKS;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned LAT  = lat_of(OUT_REGS);

  logic [PW-1:0]         rr_q      [NUM_BANKS];
  logic [PW-1:0]         rr_d      [NUM_BANKS];
  logic [BKW-1:0]        port_bank [NUM_PORTS];
  logic [NUM_BANKS-1:0]  bk_en;
  logic [NUM_BANKS-1:0]  bk_we;
  logic [RW-1:0]         bk_row    [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bk_wdata  [NUM_BANKS];
  logic [BW-1:0]         bk_be     [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bk_rdata  [NUM_BANKS];
  rsp_ent_t              rsp_q     [NUM_PORTS][LAT];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      port_bank[p] = BKW'(bank_of(32'(addr_i[p]), NUM_BANKS));
  end

  // Two passes per bank: ports at/above the pointer first, then the wrapped ones.
  always_comb begin
    gnt_o = '0;
    bk_en = '0;
    bk_we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bk_row[b]   = '0;
      bk_wdata[b] = '0;
      bk_be[b]    = '0;
      rr_d[b]     = rr_q[b];
      for (int pass = 0; pass < 2; pass++) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!bk_en[b] && rst_ni && req_i[p] && port_bank[p] == BKW'(b) &&
              ((pass == 0) == (PW'(p) >= rr_q[b]))) begin
            bk_en[b]    = 1'b1;
            gnt_o[p]    = 1'b1;
            bk_we[b]    = we_i[p];
            bk_row[b]   = RW'(row_of(32'(addr_i[p]), NUM_BANKS));
            bk_wdata[b] = wdata_i[p];
            bk_be[b]    = be_i[p];
            rr_d[b]     = (p == int'(NUM_PORTS) - 1) ? '0 : PW'(p + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= rr_d[b];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_bank_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_ROWS   (ROWS),
      .OUT_REGS   (OUT_REGS)
    ) u_bank (
      .clk_i   (clk_i),
      .en_i    (bk_en[b]),
      .we_i    (bk_we[b]),
      .row_i   (bk_row[b]),
      .wdata_i (bk_wdata[b]),
      .be_i    (bk_be[b]),
      .rdata_o (bk_rdata[b])
    );
  end

  // Response pipeline: stage 0 captures granted reads, last stage steers rdata.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_q[p][0].bank <= MAX_BANK_W'(port_bank[p]);
      for (int s = 1; s < LAT; s++) rsp_q[p][s].bank <= rsp_q[p][s-1].bank;
      if (!rst_ni) begin
        for (int s = 0; s < LAT; s++) rsp_q[p][s].valid <= 1'b0;
      end else begin
        rsp_q[p][0].valid <= req_i[p] && gnt_o[p] && !we_i[p];
        for (int s = 1; s < LAT; s++) rsp_q[p][s].valid <= rsp_q[p][s-1].valid;
      end
    end
  end

  // Gating with rst_ni drops a response that would surface during reset.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = rst_ni && rsp_q[p][LAT-1].valid;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rvalid_o[p] && rsp_q[p][LAT-1].bank == MAX_BANK_W'(b))
          rdata_o[p] = bk_rdata[b];
      end
    end
  end

endmodule
